dual_fetch_queue: RTL
=====================

Name: dual_fetch_queue

Overview:
- Instruction fetch queue for the superscalar core, between instruction memory and the dual-issue IF/ID decode pair.
- Owns the fetch PC and reads two consecutive instruction words per cycle.
- Buffers them in a circular queue and presents the two oldest entries to decode.
- Decode retires 0, 1 or 2 entries per cycle; a branch/jump redirect flushes the queue.

Parameters:
- DEPTH, 8: queue entries; power of two, >= 4.
- INSTR_W, 32: instruction word width.
- PC_W, 6: PC width; all PC arithmetic wraps modulo 2^PC_W.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- fetch_pc  out  PC_W  imem read address for slot 0; slot 1 reads fetch_pc+1 (wrapped).
- imem_instr0  in  INSTR_W  word at fetch_pc, combinational from imem.
- imem_instr1  in  INSTR_W  word at fetch_pc+1, combinational from imem.
- flush  in  1  redirect request from the branch/jump resolution logic.
- redirect_pc  in  PC_W  new fetch address, sampled when flush=1.
- pop_count  in  2  entries consumed by decode this cycle; legal values 0, 1, 2; 3 is treated as 2.
- out_valid0  out  1  head entry valid.
- out_valid1  out  1  head+1 entry valid.
- out_instr0  out  INSTR_W  head instruction.
- out_instr1  out  INSTR_W  head+1 instruction.
- out_pcplus1_0  out  PC_W  PC+1 of head entry.
- out_pcplus1_1  out  PC_W  PC+1 of head+1 entry.
- count  out  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, rst=0):
  - fetch_pc=0, head=0, tail=0, count=0.
  - out_valid0/1=0; storage contents are don't-care, but out_instr*/out_pcplus1_* read as 0 while not valid.
  - Reset takes effect immediately, mid-operation included; the first fetch follows the first rising edge with rst=1.
- Per-entry storage: {instr, pcplus1}.
- Outputs:
  - Combinational from storage at head and head+1 (mod DEPTH).
  - out_valid0 = (count>=1); out_valid1 = (count>=2).
  - Invalid slots drive 0.
- Effective pop: pop_eff = min(pop_count clipped to 2, count). Over-pop is silently clipped, never underflows.
- Push:
  - Condition: push = !flush && (DEPTH - count >= 2), using the pre-pop count; no combinational path from pop_count to fetch.
  - On push: write {imem_instr0, fetch_pc+1} at tail and {imem_instr1, fetch_pc+2} at tail+1.
  - Then tail += 2 and fetch_pc += 2, both wrapping.
- Non-flush update: count <= count + (push ? 2 : 0) - pop_eff; head += pop_eff (mod DEPTH). Simultaneous push and pop are both applied in the same edge.
- Flush (priority over push and pop):
  - head=tail=0, count=0, fetch_pc <= redirect_pc.
  - Imem data for that cycle is discarded.
  - The first redirected pair is pushed on the next edge and is visible at the outputs one cycle after that.
- Latency: a word read at fetch_pc in cycle N appears on out_instr* in cycle N+1 when the queue was empty.
- Full/stall behaviour:
  - With count > DEPTH-2, fetch_pc holds and no write occurs.
  - Fetch always proceeds in pairs; a single free slot is never filled.
- Wrap-around:
  - Pointers wrap mod DEPTH.
  - fetch_pc=2^PC_W-2 fetches PCs 62,63 with pcplus1 63,0; next fetch_pc=0.
  - fetch_pc=2^PC_W-1 fetches PCs 63,0.
- Invariants: 0 <= count <= DEPTH; count always equals the number of written-but-unpopped entries.

Test Plan:
- Reset: imem returns word=PC; assert rst=0 mid-run with count=6 -> count=0, fetch_pc=0, out_valid0/1=0 immediately; release -> after 1 edge count=2, out_instr0=0, out_instr1=1, out_pcplus1_0=1.
- Fill, no pop: count 2,4,6,8 on successive edges, then fetch_pc holds at 8 and count stays 8; outputs stay instr 0/1.
- Steady dual issue: pop_count=2 every cycle after the first push -> count constant at 2; out_instr0 sequence 0,2,4,…; no gaps.
- Odd pops with storage wrap: alternate pop 1/2 for 20 cycles -> outputs strictly sequential PCs; count never exceeds 8; head wraps 7->0 without corruption.
- Flush with concurrent pop: count=6, pop_count=2, flush=1, redirect_pc=0x2A -> next edge count=0, fetch_pc=0x2A; the following edge gives out_instr0=0x2A, out_instr1=0x2B.
- PC wrap and over-pop: redirect to 62 -> entries 62,63 (pcplus1 63,0), then fetch_pc=0; with count=1, pop_count=2 -> count=0, no underflow, out_valid0=0.

Source files
------------

// File: rtl/dual_fetch_queue_if.sv
// Bundles the imem fetch path, the redirect request and the dual decode
// outputs of the instruction fetch queue.
interface dual_fetch_queue_if #(
  parameter int DEPTH   = 8,
  parameter int INSTR_W = 32,
  parameter int PC_W    = 6
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PC_W-1:0]    fetch_pc;
  logic [INSTR_W-1:0] imem_instr0;
  logic [INSTR_W-1:0] imem_instr1;
  logic               flush;
  logic [PC_W-1:0]    redirect_pc;
  logic [1:0]         pop_count;
  logic               out_valid0;
  logic               out_valid1;
  logic [INSTR_W-1:0] out_instr0;
  logic [INSTR_W-1:0] out_instr1;
  logic [PC_W-1:0]    out_pcplus1_0;
  logic [PC_W-1:0]    out_pcplus1_1;
  logic [CW-1:0]      count;

  modport slave (
    output fetch_pc,
    input  imem_instr0, imem_instr1, flush, redirect_pc, pop_count,
    output out_valid0, out_valid1, out_instr0, out_instr1,
    output out_pcplus1_0, out_pcplus1_1, count
  );

  modport master (
    input  fetch_pc,
    output imem_instr0, imem_instr1, flush, redirect_pc, pop_count,
    input  out_valid0, out_valid1, out_instr0, out_instr1,
    input  out_pcplus1_0, out_pcplus1_1, count
  );
endinterface

// File: rtl/dual_fetch_queue.sv
// Dual-issue instruction fetch queue: fetches two words per cycle into a
// circular buffer and presents the two oldest entries to decode.
module dual_fetch_queue #(
  parameter int DEPTH   = 8,
  parameter int INSTR_W = 32,
  parameter int PC_W    = 6
) (
  input logic              clk,
  input logic              rst,
  dual_fetch_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [INSTR_W-1:0] r_instr [DEPTH];
  logic [PC_W-1:0]    r_pcp   [DEPTH];
  logic [AW-1:0]      r_head;
  logic [AW-1:0]      r_tail;
  logic [CW-1:0]      r_count;
  logic [PC_W-1:0]    r_fetch_pc;

  logic [AW-1:0]      w_head1;
  logic [AW-1:0]      w_tail1;
  logic [PC_W-1:0]    w_pc_p1;
  logic [PC_W-1:0]    w_pc_p2;
  logic [1:0]         w_pop_clip;
  logic [CW-1:0]      w_pop_eff;
  logic               w_push;
  logic               w_valid0;
  logic               w_valid1;

  assign w_head1 = r_head + AW'(1);
  assign w_tail1 = r_tail + AW'(1);
  assign w_pc_p1 = r_fetch_pc + PC_W'(1);
  assign w_pc_p2 = r_fetch_pc + PC_W'(2);

  // Pop request of 3 counts as 2, and never more than what is stored.
  assign w_pop_clip = (bus.pop_count == 2'd3) ? 2'd2 : bus.pop_count;
  assign w_pop_eff  = (CW'(w_pop_clip) > r_count) ? r_count : CW'(w_pop_clip);

  // Fetch decision uses the pre-pop occupancy so pop_count never reaches fetch.
  assign w_push = !bus.flush && (r_count <= CW'(DEPTH - 2));

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[r_tail]  <= bus.imem_instr0;
      r_pcp[r_tail]    <= w_pc_p1;
      r_instr[w_tail1] <= bus.imem_instr1;
      r_pcp[w_tail1]   <= w_pc_p2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_fetch_pc <= '0;
    end else if (bus.flush) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_fetch_pc <= bus.redirect_pc;
    end else begin
      if (w_push) begin
        r_tail     <= r_tail + AW'(2);
        r_fetch_pc <= r_fetch_pc + PC_W'(2);
      end
      r_head  <= r_head + w_pop_eff[AW-1:0];
      r_count <= r_count + (w_push ? CW'(2) : CW'(0)) - w_pop_eff;
    end
  end

  assign w_valid0 = (r_count != '0);
  assign w_valid1 = (r_count >= CW'(2));

  assign bus.fetch_pc      = r_fetch_pc;
  assign bus.count         = r_count;
  assign bus.out_valid0    = w_valid0;
  assign bus.out_valid1    = w_valid1;
  assign bus.out_instr0    = w_valid0 ? r_instr[r_head]  : '0;
  assign bus.out_instr1    = w_valid1 ? r_instr[w_head1] : '0;
  assign bus.out_pcplus1_0 = w_valid0 ? r_pcp[r_head]    : '0;
  assign bus.out_pcplus1_1 = w_valid1 ? r_pcp[w_head1]   : '0;
endmodule
